// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the register file's single write port from the load and ALU paths.
// Optional pending-data forwarding to the decode read ports is enabled by defining WB_FORWARD_EN.
module reg_writeback_queue #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 5,
    parameter  int DW    = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    output logic          regwrite,
    output logic [AW-1:0] write_reg,
    output logic [DW-1:0] write_data,
    output logic [CW-1:0] pending,
    output logic          full,
    input  logic [AW-1:0] fwd_rs1,
    input  logic [AW-1:0] fwd_rs2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2
);

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wptr, rptr, alu_slot;
    logic [CW-1:0] count;
    logic [CW:0]   free;
    logic          pop, ld_push, alu_push, ld_nz;

    // The head drains every cycle it exists, so that slot is already free for this cycle's pushes.
    assign pop      = (count != '0);
    assign free     = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    assign ld_nz    = ld_valid && (ld_rd != '0);

    assign ld_ready  = !reset && (free >= (CW+1)'(1));
    assign alu_ready = !reset && (ld_nz ? (free >= (CW+1)'(2)) : (free >= (CW+1)'(1)));

    // x0 requests handshake normally but never occupy a slot.
    assign ld_push  = ld_nz && ld_ready;
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign alu_slot = wptr + PW'(ld_push);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (ld_push) begin
                rd_mem[wptr]   <= ld_rd;
                data_mem[wptr] <= ld_data;
            end
            if (alu_push) begin
                rd_mem[alu_slot]   <= alu_rd;
                data_mem[alu_slot] <= alu_data;
            end
            wptr  <= wptr + PW'(ld_push) + PW'(alu_push);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Popped slots keep stale contents, so the write port is gated by occupancy.
    assign regwrite   = pop;
    assign write_reg  = pop ? rd_mem[rptr]   : '0;
    assign write_data = pop ? data_mem[rptr] : '0;
    assign pending    = count;
    assign full       = (count == CW'(DEPTH));

`ifdef WB_FORWARD_EN
    // Walk oldest to newest so the last match left standing is the newest pending write.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (fwd_rs1 != '0 && rd_mem[rptr + PW'(i)] == fwd_rs1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_mem[rptr + PW'(i)];
                end
                if (fwd_rs2 != '0 && rd_mem[rptr + PW'(i)] == fwd_rs2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_mem[rptr + PW'(i)];
                end
            end
        end
    end
`else
    // Lookup ports are folded into constant-zero terms so they stay connected but inert.
    assign fwd_hit1  = &{1'b0, fwd_rs1};
    assign fwd_hit2  = &{1'b0, fwd_rs2};
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: accepted writes are queued in order and
// matched against each register-file write seen on the falling edge.
module tb_reg_writeback_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        ld_valid, alu_valid;
    logic [4:0]  ld_rd, alu_rd, fwd_rs1, fwd_rs2;
    logic [31:0] ld_data, alu_data;
    logic        ld_ready, alu_ready, regwrite, full;
    logic [4:0]  write_reg;
    logic [31:0] write_data, fwd_data1, fwd_data2;
    logic [2:0]  pending;
    logic        fwd_hit1, fwd_hit2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  passed = 0;
    int  total  = 0;
    int  m_cnt  = 0;
    bit  exp_ld_rdy, exp_alu_rdy;

    reg_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .pending(pending), .full(full),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clock = ~clock;

    // Each write is live for one full cycle; the falling edge sees it exactly once.
    always @(negedge clock) begin
        if (!reset && regwrite === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", write_reg, write_data);
            end else begin
                mon_e = sb.pop_front();
                if (write_reg !== mon_e.rd || write_data !== mon_e.data)
                    $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                             write_reg, write_data, mon_e.rd, mon_e.data);
                else
                    passed++;
            end
        end
    end

    // Drive one cycle of requests and record what the bench expects to be accepted.
    task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad);
        int fr;
        int pushes;
        @(negedge clock);
        ld_valid = lv;  ld_rd = lr;  ld_data = ldd;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        #1;
        fr = 4 - m_cnt + ((m_cnt != 0) ? 1 : 0);
        exp_ld_rdy  = (fr >= 1);
        exp_alu_rdy = (lv && lr != 0) ? (fr >= 2) : (fr >= 1);
        pushes = 0;
        if (lv && exp_ld_rdy && lr != 0) begin
            sb.push_back('{lr, ldd});
            pushes++;
        end
        if (av && exp_alu_rdy && ar != 0) begin
            sb.push_back('{ar, ad});
            pushes++;
        end
        m_cnt = m_cnt + pushes - ((m_cnt != 0) ? 1 : 0);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        fwd_rs1 = 0; fwd_rs2 = 0;
        #12;
        total++;
        if (regwrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 ||
            pending !== 3'd0 || full !== 1'b0 || ld_ready !== 1'b0 || alu_ready !== 1'b0)
            $display("FAIL reset_outputs: got rw=%b reg=%0d data=%h pend=%0d full=%b rdy=%b%b, required all 0",
                     regwrite, write_reg, write_data, pending, full, ld_ready, alu_ready);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (regwrite !== 1'b0 || pending !== 3'd0 || ld_ready !== 1'b1)
            $display("FAIL post_reset: got rw=%b pend=%0d ld_ready=%b, required 0 0 1", regwrite, pending, ld_ready);
        else passed++;
    endtask

    task automatic test_single();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        total++;
        if (alu_ready !== 1'b1) $display("FAIL single_ready: got %b, required 1", alu_ready);
        else passed++;
        idle();
        total++;
        if (regwrite !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEAD_BEEF || pending !== 3'd1)
            $display("FAIL single_write: got rw=%b reg=%0d data=%h pend=%0d, required 1 5 deadbeef 1",
                     regwrite, write_reg, write_data, pending);
        else passed++;
        idle();
        total++;
        if (regwrite !== 1'b0 || pending !== 3'd0)
            $display("FAIL single_drained: got rw=%b pend=%0d, required 0 0", regwrite, pending);
        else passed++;
    endtask

    task automatic test_dual();
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        total++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b1)
            $display("FAIL dual_ready: got ld=%b alu=%b, required 1 1", ld_ready, alu_ready);
        else passed++;
        idle();
        total++;
        if (pending !== 3'd2 || write_reg !== 5'd3)
            $display("FAIL dual_first: got pend=%0d reg=%0d, required 2 3", pending, write_reg);
        else passed++;
        idle();
        total++;
        if (pending !== 3'd1 || write_reg !== 5'd4)
            $display("FAIL dual_second: got pend=%0d reg=%0d, required 1 4", pending, write_reg);
        else passed++;
        idle();
        total++;
        if (pending !== 3'd0 || regwrite !== 1'b0)
            $display("FAIL dual_drained: got pend=%0d rw=%b, required 0 0", pending, regwrite);
        else passed++;
    endtask

    task automatic test_x0();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        total++;
        if (alu_ready !== 1'b1) $display("FAIL x0_alu_ready: got %b, required 1", alu_ready);
        else passed++;
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        total++;
        if (ld_ready !== 1'b1 || pending !== 3'd0)
            $display("FAIL x0_ld: got ready=%b pend=%0d, required 1 0", ld_ready, pending);
        else passed++;
        idle();
        total++;
        if (pending !== 3'd0 || regwrite !== 1'b0)
            $display("FAIL x0_discard: got pend=%0d rw=%b, required 0 0", pending, regwrite);
        else passed++;
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 5'(2*k+1), 32'h100 + 32'(2*k), 1'b1, 5'(2*k+2), 32'h101 + 32'(2*k));
            total++;
            if (ld_ready !== exp_ld_rdy || alu_ready !== exp_alu_rdy)
                $display("FAIL fill_ready[%0d]: got ld=%b alu=%b, required %b %b",
                         k, ld_ready, alu_ready, exp_ld_rdy, exp_alu_rdy);
            else passed++;
            if (k == 3) begin
                total++;
                if (full !== 1'b1 || pending !== 3'd4 || ld_ready !== 1'b1 || alu_ready !== 1'b0)
                    $display("FAIL full_stall: got full=%b pend=%0d ld=%b alu=%b, required 1 4 1 0",
                             full, pending, ld_ready, alu_ready);
                else passed++;
            end
        end
        for (int k = 6; k < 9; k++) begin
            drive(1'b1, 5'(13+k), 32'h200 + 32'(k), 1'b0, 5'd0, 32'd0);
            total++;
            if (full !== 1'b1 || ld_ready !== 1'b1)
                $display("FAIL full_pushpop[%0d]: got full=%b ld=%b, required 1 1", k, full, ld_ready);
            else passed++;
        end
        repeat (5) idle();
        total++;
        if (pending !== 3'd0 || full !== 1'b0 || sb.size() != 0)
            $display("FAIL wrap_drain: got pend=%0d full=%b left=%0d, required 0 0 0", pending, full, sb.size());
        else passed++;
    endtask

    task automatic test_forward();
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd0;
        idle();
        total++;
`ifdef WB_FORWARD_EN
        if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hB || fwd_hit2 !== 1'b0)
            $display("FAIL forward: got hit1=%b data1=%h hit2=%b, required 1 0000000b 0", fwd_hit1, fwd_data1, fwd_hit2);
        else passed++;
`else
        if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0 || fwd_data1 !== 32'd0 || fwd_data2 !== 32'd0)
            $display("FAIL forward_off: got hit1=%b hit2=%b data1=%h, required 0 0 0", fwd_hit1, fwd_hit2, fwd_data1);
        else passed++;
`endif
        fwd_rs1 = 5'd0;
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd9, 32'h91, 1'b1, 5'd10, 32'h92);
        drive(1'b1, 5'd11, 32'h93, 1'b1, 5'd12, 32'h94);
        @(negedge clock);
        ld_valid = 0; alu_valid = 0;
        #1 reset = 1'b1;
        #1;
        total++;
        if (regwrite !== 1'b0 || pending !== 3'd0 || write_data !== 32'd0 || alu_ready !== 1'b0)
            $display("FAIL reset_mid: got rw=%b pend=%0d data=%h alu_ready=%b, required 0 0 0 0",
                     regwrite, pending, write_data, alu_ready);
        else passed++;
        sb.delete();
        m_cnt = 0;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) idle();
        total++;
        if (pending !== 3'd0 || regwrite !== 1'b0)
            $display("FAIL reset_no_write: got pend=%0d rw=%b, required 0 0", pending, regwrite);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_x0();
        test_full_wrap();
        test_forward();
        test_reset_mid();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d left, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
